hash_table_cmd_queue: RTL and testbench
=======================================

HASH_TABLE_CMD_QUEUE -- requirements
Module: hash_table_cmd_queue

Interface
REQ-001 Parameter KEY_WIDTH, default 32, is the key width and SHALL match the downstream hash table.
REQ-002 Parameter VALUE_WIDTH, default 32, is the value width.
REQ-003 Parameter CHAINING_SIZE, default 4, sets collision count width to $clog2(CHAINING_SIZE).
REQ-004 Parameter QUEUE_DEPTH, default 4 (power of two, >=2), is the number of buffered commands.
REQ-005 Parameter TIMEOUT_CYCLES, default 64, is the maximum wait for ht_op_done.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 Ports, clock and reset first:
 clk  in  1  clock, all logic rising-edge
 rst  in  1  asynchronous active-low reset
 cmd_valid  in  1  command offered
 cmd_ready  out  1  command accepted when both high
 cmd_op  in  2  00 insert, 01 delete, 10 search, 11 illegal
 cmd_key  in  KEY_WIDTH  command key
 cmd_value  in  VALUE_WIDTH  insert value
 ht_op_en  out  1  one-cycle start pulse to hash table
 ht_op_sel  out  2  op to hash table
 ht_key  out  KEY_WIDTH  key to hash table
 ht_value  out  VALUE_WIDTH  value to hash table
 ht_value_out  in  VALUE_WIDTH  search result
 ht_op_done  in  1  hash table completion
 ht_op_error  in  1  hash table FULL / KEY_NOT_FOUND
 ht_collision_count  in  $clog2(CHAINING_SIZE)  chain occupancy
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed when both high
 rsp_op  out  2  op of completed command
 rsp_key  out  KEY_WIDTH  key of completed command
 rsp_value  out  VALUE_WIDTH  search value, else 0
 rsp_error  out  1  hash error, illegal op, or timeout
 rsp_timeout  out  1  ht_op_done not seen in time
 rsp_collision  out  $clog2(CHAINING_SIZE)  captured ht_collision_count

Function
REQ-008 Commands SHALL be buffered in-order in a QUEUE_DEPTH FIFO; cmd_ready = not full, independent of cmd_valid.
REQ-009 Push and head pop in the same cycle SHALL leave occupancy unchanged, including when full.
REQ-010 FSM states IDLE, ISSUE, WAIT, RESP; one command in flight at a time.
REQ-011 IDLE: FIFO non-empty and head op legal -> ISSUE; head op 11 -> RESP with rsp_error=1, no ht_op_en.
REQ-012 ISSUE: ht_op_en high exactly one cycle, then -> WAIT; minimum cmd handshake to ht_op_en is 2 cycles.
REQ-013 ht_op_sel, ht_key, ht_value SHALL be registered from the FIFO head and held stable from ISSUE through WAIT.
REQ-014 WAIT: ht_op_done high -> capture ht_op_error, ht_collision_count, ht_value_out (search only, else 0) -> RESP.
REQ-015 WAIT: cycle counter reaching TIMEOUT_CYCLES-1 without ht_op_done -> RESP with rsp_error=1, rsp_timeout=1.
REQ-016 ht_op_done outside WAIT SHALL be ignored.
REQ-017 RESP: rsp_valid held with stable rsp_* until rsp_ready; on handshake pop FIFO head, -> IDLE.
REQ-018 Back-to-back: next ht_op_en no earlier than 2 cycles after the previous response handshake.
REQ-019 Responses SHALL be returned in command order, exactly one per accepted command.

Reset
REQ-020 rst low SHALL asynchronously clear FIFO pointers/count, state to IDLE, timeout counter to 0.
REQ-021 Reset values: ht_op_en, rsp_valid, rsp_error, rsp_timeout = 0; all data outputs = 0; cmd_ready = 1 after release.
REQ-022 Reset mid-operation SHALL discard queued and in-flight commands with no response.

Structure
REQ-023 Op encodings and FSM state enum SHALL live in shared package hash_table_pkg.
REQ-024 The FIFO SHALL be a sub-module hash_cmd_fifo (sync, show-ahead head).

Verification
REQ-025 Insert key=5 value=0xAA, ht_op_done after 3 cycles error=0 -> rsp op=00 key=5 value=0 error=0.
REQ-026 Search key=5, ht returns value_out=0xAA collision=1 -> rsp value=0xAA collision=1 error=0.
REQ-027 Five commands with rsp_ready low, QUEUE_DEPTH=4 -> cmd_ready low after 4th; order preserved on drain.
REQ-028 cmd_op=11 -> no ht_op_en; rsp_error=1 rsp_timeout=0 within 2 cycles of head.
REQ-029 ht_op_done never asserted -> rsp_error=1 rsp_timeout=1 exactly TIMEOUT_CYCLES cycles into WAIT.
REQ-030 rst low during WAIT with 3 queued -> rsp_valid=0, cmd_ready=1, no responses after release.

Source files
------------

// File: rtl/hash_table_pkg.sv
// hash_table_pkg: op encodings and queue FSM states shared by the command queue
package hash_table_pkg;
  typedef enum logic [1:0] {OP_INSERT = 2'b00, OP_DELETE = 2'b01, OP_SEARCH = 2'b10, OP_ILLEGAL = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/hash_table_cmd_queue_if.sv
// hash_table_cmd_queue_if: command, hash-table and response channels of the queue
interface hash_table_cmd_queue_if #(
  parameter int KEY_WIDTH     = 32,
  parameter int VALUE_WIDTH   = 32,
  parameter int CHAINING_SIZE = 4
);
  localparam int CW = $clog2(CHAINING_SIZE);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [KEY_WIDTH-1:0]   cmd_key;
  logic [VALUE_WIDTH-1:0] cmd_value;
  logic                   ht_op_en;
  logic [1:0]             ht_op_sel;
  logic [KEY_WIDTH-1:0]   ht_key;
  logic [VALUE_WIDTH-1:0] ht_value;
  logic [VALUE_WIDTH-1:0] ht_value_out;
  logic                   ht_op_done;
  logic                   ht_op_error;
  logic [CW-1:0]          ht_collision_count;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_op;
  logic [KEY_WIDTH-1:0]   rsp_key;
  logic [VALUE_WIDTH-1:0] rsp_value;
  logic                   rsp_error;
  logic                   rsp_timeout;
  logic [CW-1:0]          rsp_collision;
  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_value, ht_value_out, ht_op_done, ht_op_error,
           ht_collision_count, rsp_ready,
    output cmd_ready, ht_op_en, ht_op_sel, ht_key, ht_value, rsp_valid, rsp_op, rsp_key,
           rsp_value, rsp_error, rsp_timeout, rsp_collision
  );
  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_value, ht_value_out, ht_op_done, ht_op_error,
           ht_collision_count, rsp_ready,
    input  cmd_ready, ht_op_en, ht_op_sel, ht_key, ht_value, rsp_valid, rsp_op, rsp_key,
           rsp_value, rsp_error, rsp_timeout, rsp_collision
  );
endinterface

// File: rtl/hash_cmd_fifo.sv
// hash_cmd_fifo: synchronous show-ahead FIFO holding queued commands
module hash_cmd_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rp];
  always_ff @(posedge clk) if (push_ok) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= push_ok ? wp + 1'b1 : wp;
      rp  <= pop_ok ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/hash_table_cmd_queue.sv
// hash_table_cmd_queue: buffers commands and serialises them one at a time to a hash table
module hash_table_cmd_queue
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 32,
  parameter int CHAINING_SIZE  = 4,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                    clk,
  input logic                    rst,
  hash_table_cmd_queue_if.slave  bus
);
  localparam int W  = 2 + KEY_WIDTH + VALUE_WIDTH;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t                 state, next;
  logic [W-1:0]           head;
  logic [1:0]             head_op;
  logic [KEY_WIDTH-1:0]   head_key;
  logic [VALUE_WIDTH-1:0] head_value;
  logic                   full, empty, pop, expired;
  logic [TW-1:0]          cnt;
  assign {head_op, head_key, head_value} = head;
  assign bus.cmd_ready = !full;
  assign expired       = cnt == TW'(TIMEOUT_CYCLES - 1);
  // the head stays queued while in flight and is popped only on the response handshake
  hash_cmd_fifo #(.W(W), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid && !full),
    .din   ({bus.cmd_op, bus.cmd_key, bus.cmd_value}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:  if (!empty) next = (head_op == OP_ILLEGAL) ? RESP : ISSUE;
      ISSUE: next = WAIT;
      WAIT:  if (bus.ht_op_done || expired) next = RESP;
      RESP:  if (bus.rsp_ready) next = IDLE;
    endcase
  end
  always_comb begin
    bus.ht_op_en  = state == ISSUE;
    bus.rsp_valid = state == RESP;
    pop           = state == RESP && bus.rsp_ready;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt               <= '0;
      bus.ht_op_sel     <= '0;
      bus.ht_key        <= '0;
      bus.ht_value      <= '0;
      bus.rsp_op        <= '0;
      bus.rsp_key       <= '0;
      bus.rsp_value     <= '0;
      bus.rsp_error     <= 1'b0;
      bus.rsp_timeout   <= 1'b0;
      bus.rsp_collision <= '0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      // response fields are preset at dispatch so an illegal op needs no further capture
      if (state == IDLE && !empty) begin
        bus.rsp_op        <= head_op;
        bus.rsp_key       <= head_key;
        bus.rsp_value     <= '0;
        bus.rsp_error     <= head_op == OP_ILLEGAL;
        bus.rsp_timeout   <= 1'b0;
        bus.rsp_collision <= '0;
        if (head_op != OP_ILLEGAL) begin
          bus.ht_op_sel <= head_op;
          bus.ht_key    <= head_key;
          bus.ht_value  <= head_value;
        end
      end
      if (state == WAIT && bus.ht_op_done) begin
        bus.rsp_error     <= bus.ht_op_error;
        bus.rsp_collision <= bus.ht_collision_count;
        bus.rsp_value     <= (bus.ht_op_sel == OP_SEARCH) ? bus.ht_value_out : '0;
      end else if (state == WAIT && expired) begin
        bus.rsp_error   <= 1'b1;
        bus.rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hash_table_cmd_queue.sv
// tb_hash_table_cmd_queue: directed self-checking bench for the hash table command queue
module tb_hash_table_cmd_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   en_count = 0;
  int   e0, n, rsp_seen;
  always #5 clk = ~clk;
  hash_table_cmd_queue_if #(.KEY_WIDTH(32), .VALUE_WIDTH(32), .CHAINING_SIZE(4)) bus ();
  hash_table_cmd_queue #(
    .KEY_WIDTH(32), .VALUE_WIDTH(32), .CHAINING_SIZE(4), .QUEUE_DEPTH(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always @(posedge clk) if (bus.ht_op_en) en_count <= en_count + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val);
    int k = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_key   = key;
    bus.cmd_value = val;
    while (!bus.cmd_ready && k < 100) begin tick(); k++; end
    check("send_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_en(output int cyc);
    cyc = 0;
    while (!bus.ht_op_en && cyc < 200) begin tick(); cyc++; end
    check("ht_op_en_seen", bus.ht_op_en, 1);
  endtask
  task automatic wait_rsp();
    int k = 0;
    while (!bus.rsp_valid && k < 200) begin tick(); k++; end
    check("rsp_valid_seen", bus.rsp_valid, 1);
  endtask
  task automatic pulse_done(input logic err, input logic [31:0] vout, input logic [1:0] coll);
    bus.ht_op_error        = err;
    bus.ht_value_out       = vout;
    bus.ht_collision_count = coll;
    bus.ht_op_done         = 1'b1;
    tick();
    bus.ht_op_done = 1'b0;
  endtask
  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask
  task automatic serve(input logic [31:0] key);
    int c;
    wait_en(c);
    check("fifo_order_ht_key", bus.ht_key, key);
    tick();
    pulse_done(1'b0, key + 32'h100, key[1:0]);
    wait_rsp();
    check("fifo_order_rsp_key", bus.rsp_key, key);
    check("fifo_order_rsp_value", bus.rsp_value, key + 32'h100);
    check("fifo_order_rsp_coll", bus.rsp_collision, key[1:0]);
    take_rsp();
  endtask
  initial begin
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_key = 0; bus.cmd_value = 0;
    bus.ht_value_out = 0; bus.ht_op_done = 0; bus.ht_op_error = 0;
    bus.ht_collision_count = 0; bus.rsp_ready = 0;
    tick(); tick();
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_ht_op_en", bus.ht_op_en, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_ht_key", bus.ht_key, 0);
    check("rst_rsp_value", bus.rsp_value, 0);
    rst = 1'b1;
    tick();
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    // insert key 5, completion 3 cycles into WAIT; value_out must not leak into an insert response
    send(2'b00, 32'd5, 32'hAA);
    check("insert_no_early_en", bus.ht_op_en, 0);
    tick();
    check("insert_en", bus.ht_op_en, 1);
    check("insert_sel", bus.ht_op_sel, 2'b00);
    check("insert_key", bus.ht_key, 5);
    check("insert_value", bus.ht_value, 32'hAA);
    tick();
    check("insert_en_one_cycle", bus.ht_op_en, 0);
    check("insert_key_held", bus.ht_key, 5);
    tick(); tick();
    pulse_done(1'b0, 32'h55, 2'd2);
    check("insert_rsp_valid", bus.rsp_valid, 1);
    check("insert_rsp_op", bus.rsp_op, 2'b00);
    check("insert_rsp_key", bus.rsp_key, 5);
    check("insert_rsp_value", bus.rsp_value, 0);
    check("insert_rsp_error", bus.rsp_error, 0);
    check("insert_rsp_coll", bus.rsp_collision, 2);
    take_rsp();
    check("insert_rsp_dropped", bus.rsp_valid, 0);
    // stray completion while idle is ignored
    e0 = en_count;
    pulse_done(1'b1, 32'h77, 2'd3);
    tick();
    check("stray_done_rsp_valid", bus.rsp_valid, 0);
    check("stray_done_no_en", en_count, e0);
    // search key 5 returns 0xAA with one collision
    send(2'b10, 32'd5, 32'h0);
    wait_en(n);
    check("search_latency", n, 1);
    check("search_sel", bus.ht_op_sel, 2'b10);
    tick();
    pulse_done(1'b0, 32'hAA, 2'd1);
    check("search_rsp_valid", bus.rsp_valid, 1);
    check("search_rsp_op", bus.rsp_op, 2'b10);
    check("search_rsp_value", bus.rsp_value, 32'hAA);
    check("search_rsp_coll", bus.rsp_collision, 1);
    check("search_rsp_error", bus.rsp_error, 0);
    tick(); tick(); tick();
    check("search_rsp_held", bus.rsp_valid, 1);
    check("search_rsp_value_held", bus.rsp_value, 32'hAA);
    take_rsp();
    // delete reporting a hash table error
    send(2'b01, 32'd7, 32'h0);
    wait_en(n);
    tick();
    pulse_done(1'b1, 32'h1234, 2'd3);
    check("delete_rsp_op", bus.rsp_op, 2'b01);
    check("delete_rsp_error", bus.rsp_error, 1);
    check("delete_rsp_timeout", bus.rsp_timeout, 0);
    check("delete_rsp_value", bus.rsp_value, 0);
    check("delete_rsp_coll", bus.rsp_collision, 3);
    take_rsp();
    // illegal op answered without touching the hash table
    e0 = en_count;
    send(2'b11, 32'd9, 32'h0);
    check("illegal_no_en_idle", bus.ht_op_en, 0);
    tick();
    check("illegal_rsp_valid", bus.rsp_valid, 1);
    check("illegal_rsp_error", bus.rsp_error, 1);
    check("illegal_rsp_timeout", bus.rsp_timeout, 0);
    check("illegal_rsp_op", bus.rsp_op, 2'b11);
    check("illegal_rsp_key", bus.rsp_key, 9);
    check("illegal_no_en", en_count, e0);
    take_rsp();
    // no completion: timeout exactly 64 cycles into WAIT
    send(2'b00, 32'h11, 32'h22);
    wait_en(n);
    tick();
    n = 0;
    while (!bus.rsp_valid && n < 200) begin tick(); n++; end
    check("timeout_cycles", n, 64);
    check("timeout_rsp_error", bus.rsp_error, 1);
    check("timeout_rsp_timeout", bus.rsp_timeout, 1);
    check("timeout_rsp_key", bus.rsp_key, 32'h11);
    take_rsp();
    // five commands against a four-deep queue with responses stalled
    send(2'b10, 32'hA1, 32'h0);
    send(2'b10, 32'hA2, 32'h0);
    send(2'b10, 32'hA3, 32'h0);
    send(2'b10, 32'hA4, 32'h0);
    check("full_after_4", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_key = 32'hA5; bus.cmd_value = 0;
    tick(); tick();
    check("full_held", bus.cmd_ready, 0);
    pulse_done(1'b0, 32'h1A1, 2'd1);
    check("fifo_order_first_key", bus.rsp_key, 32'hA1);
    check("fifo_order_first_value", bus.rsp_value, 32'h1A1);
    take_rsp();
    check("ready_after_pop", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    serve(32'hA2);
    serve(32'hA3);
    serve(32'hA4);
    serve(32'hA5);
    check("drained_ready", bus.cmd_ready, 1);
    // reset during WAIT with three queued discards everything
    send(2'b00, 32'hB1, 32'h1);
    send(2'b00, 32'hB2, 32'h2);
    send(2'b00, 32'hB3, 32'h3);
    check("pre_reset_rsp_valid", bus.rsp_valid, 0);
    e0 = en_count;
    rst = 1'b0;
    #1;
    check("async_rst_rsp_valid", bus.rsp_valid, 0);
    check("async_rst_ht_op_en", bus.ht_op_en, 0);
    check("async_rst_cmd_ready", bus.cmd_ready, 1);
    check("async_rst_ht_key", bus.ht_key, 0);
    tick(); tick();
    rst = 1'b1;
    pulse_done(1'b0, 32'h99, 2'd1);
    rsp_seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.rsp_valid) rsp_seen++;
      tick();
    end
    check("post_rst_no_rsp", rsp_seen, 0);
    check("post_rst_no_en", en_count, e0);
    check("post_rst_ready", bus.cmd_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
